sort_nxn_seq: RTL and testbench
===============================

Name: sort_nxn_seq

Overview:
- Multi-cycle sequencer that runs shear-sort passes on one SIZE x SIZE window using a single shared row-sorter and a single shared transposer.
- Both shared units are combinational and sit outside this block.
- Sits between the window buffer and the median-select stage of the median filter.
- Holds the window in an internal register and alternates sort and transpose steps. Then it presents the result matrix and center cell under a valid/ready handshake.

Parameters:
- SIZE, 3, window edge length (number of rows and columns).
- DATA_WIDTH, 8, bits per pixel.
- PASSES, 2, number of sort+transpose pass pairs. Must be ≥ 1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; returns to IDLE and drops result.
- in_data  input  SIZE*SIZE*DATA_WIDTH  incoming window. cell[i][j] at bits [SIZE*(SIZE-i)*DATA_WIDTH - j*DATA_WIDTH - 1 -: DATA_WIDTH].
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a window.
- sort_data  output  SIZE*SIZE*DATA_WIDTH  operand to external row-sorter; equals work register.
- sort_result  input  SIZE*SIZE*DATA_WIDTH  row-sorted sort_data, ascending per row, cell[i][0] smallest.
- trans_data  output  SIZE*SIZE*DATA_WIDTH  operand to external transposer; equals work register.
- trans_result  input  SIZE*SIZE*DATA_WIDTH  transpose of trans_data.
- out_data  output  SIZE*SIZE*DATA_WIDTH  final matrix.
- out_center  output  DATA_WIDTH  out_data cell[SIZE/2][SIZE/2].
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- busy  output  1  high in SORT or TRANS.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, work register=0, step counter=0.
  - in_ready=1, out_valid=0, busy=0, out_data=0, out_center=0.
- States: IDLE, SORT, TRANS, DONE. Step counter width $clog2(PASSES)+1.
- IDLE:
  - in_ready=1.
  - On in_valid: work<=in_data, counter<=0, go SORT.
- SORT:
  - busy=1, in_ready=0.
  - work<=sort_result, go TRANS.
- TRANS:
  - busy=1.
  - work<=trans_result, counter<=counter+1.
  - If counter==PASSES-1, go DONE; else go SORT.
- DONE:
  - out_valid=1, out_data=work, out_center=center cell.
  - Outputs stable while out_valid && !out_ready.
  - On out_ready: go IDLE, out_valid<=0.
  - No new input is accepted in DONE (in_ready=0); no skid path.
- Latency: in_valid accepted at edge N gives out_valid high from edge N+2*PASSES+1. PASSES=2 gives 5 cycles.
- Throughput: one window per 2*PASSES+2 cycles when out_ready is held high.
- sort_data and trans_data are always driven from the work register. Only the state selects which result is captured.
- flush:
  - Has priority over every transition.
  - Next cycle: state=IDLE, out_valid=0, counter=0. Work register is held.
- flush together with in_valid in IDLE: flush wins and the window is not captured.
- in_valid outside IDLE is ignored; in_ready=0 tells the upstream to hold.
- rst_n asserted mid-sequence returns immediately to reset values. No partial result is emitted.
- out_ready is ignored unless in DONE.

Test Plan:
- Ordered window: SIZE=3, PASSES=2, rows [9,8,7],[6,5,4],[3,2,1], pulse in_valid, out_ready=1 → out_valid after 5 cycles, out_data rows [1,2,3],[4,5,6],[7,8,9], out_center=5, busy high for exactly 4 cycles.
- Backpressure: same window, out_ready=0 for 10 cycles → out_valid held, out_data stable, in_ready=0. Raise out_ready → next cycle out_valid=0, in_ready=1.
- Back-to-back: in_valid held high with windows A=[9..1] then B=all 0x10, out_ready=1 → B accepted exactly 6 cycles after A. Results are A sorted, then B with out_center=0x10.
- Flush mid-sequence: assert flush in TRANS of pass 0 → next cycle IDLE, out_valid never asserts for that window, in_ready=1.
- Async reset in SORT: rst_n low for 1 ns between edges → outputs take reset values immediately. After release, a new window completes normally with 5-cycle latency.
- Parameter sweep: SIZE=5, PASSES=3, random window → latency 7 cycles. out_data equals a bench model of three row-sort+transpose passes.

Source files
------------

// File: rtl/sort_nxn_seq.sv
// Shear-sort sequencer: alternates external row-sort and transpose on one window; result after 2*PASSES steps.
// Latency: accept edge N -> out_valid sampled at edge N+2*PASSES+1; holds result while !out_ready; in_ready only in IDLE.
module sort_nxn_seq #(
    parameter int SIZE       = 3,
    parameter int DATA_WIDTH = 8,
    parameter int PASSES     = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic [SIZE*SIZE*DATA_WIDTH-1:0] in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [SIZE*SIZE*DATA_WIDTH-1:0] sort_data,
    input  logic [SIZE*SIZE*DATA_WIDTH-1:0] sort_result,
    output logic [SIZE*SIZE*DATA_WIDTH-1:0] trans_data,
    input  logic [SIZE*SIZE*DATA_WIDTH-1:0] trans_result,
    output logic [SIZE*SIZE*DATA_WIDTH-1:0] out_data,
    output logic [DATA_WIDTH-1:0]           out_center,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy
);

    localparam int W     = SIZE*SIZE*DATA_WIDTH;
    localparam int CW    = $clog2(PASSES) + 1;
    localparam int MID   = SIZE / 2;
    localparam int C_LSB = (SIZE*SIZE - 1 - (MID*SIZE + MID)) * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SORT  = 2'd1,
        TRANS = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  work_q,  work_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    cnt_d   = '0;
                    state_d = SORT;
                end
            end
            SORT: begin
                work_d  = sort_result;
                state_d = TRANS;
            end
            TRANS: begin
                work_d  = trans_result;
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(PASSES - 1)) ? DONE : SORT;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort keeps the work register so the datapath does not toggle needlessly.
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            work_d  = work_q;
        end
    end

    assign sort_data  = work_q;
    assign trans_data = work_q;
    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q == SORT) || (state_q == TRANS);
    assign out_valid  = (state_q == DONE);
    assign out_data   = out_valid ? work_q : '0;
    assign out_center = out_valid ? work_q[C_LSB +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_sort_nxn_seq.sv
// Directed bench for sort_nxn_seq: external sorter/transposer models plus a result scoreboard per DUT.
module tb_sort_nxn_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 3x3, PASSES=2 instance
    logic        flush3 = 1'b0, in_valid3 = 1'b0, out_ready3 = 1'b0;
    logic [71:0] in_data3 = '0;
    logic [71:0] sd3, sr3, td3, tr3, od3;
    logic [7:0]  oc3;
    logic        in_ready3, ov3, busy3;

    // 5x5, PASSES=3 instance
    logic         flush5 = 1'b0, in_valid5 = 1'b0, out_ready5 = 1'b0;
    logic [199:0] in_data5 = '0;
    logic [199:0] sd5, sr5, td5, tr5, od5;
    logic [7:0]   oc5;
    logic         in_ready5, ov5, busy5;

    sort_nxn_seq #(.SIZE(3), .DATA_WIDTH(8), .PASSES(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .sort_data(sd3), .sort_result(sr3), .trans_data(td3), .trans_result(tr3),
        .out_data(od3), .out_center(oc3), .out_valid(ov3), .out_ready(out_ready3),
        .busy(busy3)
    );

    sort_nxn_seq #(.SIZE(5), .DATA_WIDTH(8), .PASSES(3)) dut5 (
        .clk(clk), .rst_n(rst_n), .flush(flush5),
        .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
        .sort_data(sd5), .sort_result(sr5), .trans_data(td5), .trans_result(tr5),
        .out_data(od5), .out_center(oc5), .out_valid(ov5), .out_ready(out_ready5),
        .busy(busy5)
    );

    function automatic logic [7:0] getc(input logic [199:0] m, input int n, input int i, input int j);
        return m[(n*n - 1 - (i*n + j))*8 +: 8];
    endfunction

    function automatic logic [199:0] putc(input logic [199:0] m, input int n, input int i, input int j,
                                          input logic [7:0] v);
        logic [199:0] r;
        r = m;
        r[(n*n - 1 - (i*n + j))*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [199:0] row_sort(input logic [199:0] m, input int n);
        logic [199:0] r;
        logic [7:0]   row [5];
        logic [7:0]   t;
        r = m;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) row[j] = getc(m, n, i, j);
            for (int a = 0; a < n - 1; a++)
                for (int b = 0; b < n - 1 - a; b++)
                    if (row[b] > row[b+1]) begin
                        t = row[b]; row[b] = row[b+1]; row[b+1] = t;
                    end
            for (int j = 0; j < n; j++) r = putc(r, n, i, j, row[j]);
        end
        return r;
    endfunction

    function automatic logic [199:0] transpose(input logic [199:0] m, input int n);
        logic [199:0] r;
        r = m;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                r = putc(r, n, i, j, getc(m, n, j, i));
        return r;
    endfunction

    function automatic logic [199:0] shear(input logic [199:0] m, input int n, input int p);
        logic [199:0] r;
        r = m;
        for (int k = 0; k < p; k++) r = transpose(row_sort(r, n), n);
        return r;
    endfunction

    function automatic logic [199:0] rnd_window();
        logic [199:0] r;
        r = '0;
        for (int k = 0; k < 25; k++) r[k*8 +: 8] = 8'($urandom_range(0, 255));
        return r;
    endfunction

    // External combinational row-sorter and transposer seen by each DUT
    logic [199:0] s3w, t3w;
    always_comb begin
        s3w = row_sort(200'(sd3), 3);
        t3w = transpose(200'(td3), 3);
        sr3 = s3w[71:0];
        tr3 = t3w[71:0];
    end
    always_comb begin
        sr5 = row_sort(sd5, 5);
        tr5 = transpose(td5, 5);
    end

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [199:0] q3 [$];
    logic [199:0] q5 [$];

    // Scoreboards: compare on each accepted result (valid && ready at the coming edge)
    always @(negedge clk) begin
        logic [199:0] e;
        if (rst_n && ov3 && out_ready3) begin
            if (q3.size() == 0) chk("sb3_unexpected", 200'(1), 200'(0));
            else begin
                e = q3.pop_front();
                chk("sb3_data", 200'(od3), e);
                chk("sb3_center", 200'(oc3), 200'(getc(e, 3, 1, 1)));
            end
        end
        if (rst_n && ov5 && out_ready5) begin
            if (q5.size() == 0) chk("sb5_unexpected", 200'(1), 200'(0));
            else begin
                e = q5.pop_front();
                chk("sb5_data", od5, e);
                chk("sb5_center", 200'(oc5), 200'(getc(e, 5, 2, 2)));
            end
        end
    end

    // Called just after a rising edge with dut3 in IDLE; returns just after the accepting edge.
    task automatic accept3(input logic [71:0] d, input bit push);
        in_valid3 = 1'b1;
        in_data3  = d;
        @(negedge clk);
        chk("accept_in_ready", 200'(in_ready3), 200'(1));
        @(posedge clk);
        #1 in_valid3 = 1'b0;
        if (push) q3.push_back(shear(200'(d), 3, 2));
    endtask

    // Edges from the accepting edge to the first edge that samples out_valid high.
    task automatic wait_valid3(output int cyc, output int bcnt);
        cyc  = 1;
        bcnt = 0;
        @(negedge clk);
        while (!ov3 && cyc < 40) begin
            if (busy3) bcnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic drain3();
        int t = 0;
        while (q3.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("drain3", 200'(q3.size()), 200'(0));
    endtask

    initial begin
        logic [71:0]  win_a, win_b, win_c;
        logic [199:0] rw;
        logic [71:0]  snap;
        int lat, bcnt, bad, gap, seen, t;

        win_a = 72'h09_08_07_06_05_04_03_02_01;
        win_b = {9{8'h10}};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 200'(in_ready3), 200'(1));
        chk("rst_out_valid", 200'(ov3), 200'(0));
        chk("rst_busy", 200'(busy3), 200'(0));
        chk("rst_out_data", 200'(od3), 200'(0));
        chk("rst_out_center", 200'(oc3), 200'(0));
        chk("rst5_in_ready", 200'(in_ready5), 200'(1));
        rst_n = 1'b1;

        // Ordered window
        @(posedge clk); #1;
        out_ready3 = 1'b1;
        accept3(win_a, 1'b1);
        wait_valid3(lat, bcnt);
        chk("ord_latency", 200'(lat), 200'(5));
        chk("ord_busy_cycles", 200'(bcnt), 200'(4));
        chk("ord_data", 200'(od3), 200'(72'h01_02_03_04_05_06_07_08_09));
        chk("ord_center", 200'(oc3), 200'(8'd5));
        @(posedge clk); #1;
        @(negedge clk);
        chk("ord_after_valid", 200'(ov3), 200'(0));
        chk("ord_after_in_ready", 200'(in_ready3), 200'(1));

        // Backpressure
        @(posedge clk); #1;
        out_ready3 = 1'b0;
        accept3(win_a, 1'b1);
        wait_valid3(lat, bcnt);
        chk("bp_latency", 200'(lat), 200'(5));
        snap = od3;
        bad  = 0;
        repeat (10) begin
            if (!ov3 || od3 !== snap || in_ready3) bad++;
            @(negedge clk);
        end
        chk("bp_hold", 200'(bad), 200'(0));
        @(posedge clk); #1;
        out_ready3 = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_release_valid", 200'(ov3), 200'(0));
        chk("bp_release_in_ready", 200'(in_ready3), 200'(1));

        // Back-to-back with in_valid held high
        @(posedge clk); #1;
        in_valid3 = 1'b1;
        in_data3  = win_a;
        @(posedge clk);
        q3.push_back(shear(200'(win_a), 3, 2));
        #1 in_data3 = win_b;
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!in_ready3 && gap < 40);
        @(posedge clk);
        q3.push_back(shear(200'(win_b), 3, 2));
        #1 in_valid3 = 1'b0;
        chk("b2b_gap", 200'(gap), 200'(6));
        drain3();

        // Flush during TRANS of pass 0
        @(posedge clk); #1;
        rw = rnd_window();
        win_c = rw[71:0];
        accept3(win_c, 1'b0);
        @(posedge clk); #1;
        chk("flush_in_trans_busy", 200'(busy3), 200'(1));
        flush3 = 1'b1;
        @(posedge clk); #1;
        flush3 = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", 200'(in_ready3), 200'(1));
        chk("flush_busy", 200'(busy3), 200'(0));
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (ov3) seen++;
        end
        chk("flush_no_valid", 200'(seen), 200'(0));

        // Flush together with in_valid in IDLE
        @(posedge clk); #1;
        in_valid3 = 1'b1;
        in_data3  = win_a;
        flush3    = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        flush3    = 1'b0;
        @(negedge clk);
        chk("flush_idle_busy", 200'(busy3), 200'(0));
        chk("flush_idle_in_ready", 200'(in_ready3), 200'(1));

        // Asynchronous reset while in SORT
        @(posedge clk); #1;
        accept3(win_c, 1'b0);
        @(negedge clk);
        chk("arst_pre_busy", 200'(busy3), 200'(1));
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 200'(busy3), 200'(0));
        chk("arst_in_ready", 200'(in_ready3), 200'(1));
        chk("arst_out_valid", 200'(ov3), 200'(0));
        chk("arst_out_data", 200'(od3), 200'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        rw = rnd_window();
        accept3(rw[71:0], 1'b1);
        wait_valid3(lat, bcnt);
        chk("arst_next_latency", 200'(lat), 200'(5));
        drain3();

        // SIZE=5, PASSES=3
        @(posedge clk); #1;
        rw         = rnd_window();
        in_data5   = rw;
        in_valid5  = 1'b1;
        out_ready5 = 1'b1;
        @(posedge clk);
        q5.push_back(shear(rw, 5, 3));
        #1 in_valid5 = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!ov5 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("sz5_latency", 200'(lat), 200'(7));
        t = 0;
        while (q5.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("drain5", 200'(q5.size()), 200'(0));

        repeat (2) @(negedge clk);
        chk("final_q3_empty", 200'(q3.size()), 200'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
